// File: rtl/systolic_matmul_array.sv
// systolic_matmul_array: N x N output-stationary systolic multiplier, C = A x B.
// A is N x K and B is K x N, with K chosen per job (k_len, clamped to K_MAX).
// Ports: clk, rst (async, active-low); start/k_len/acc_mode job request;
//   a_valid/a_data/b_data operand beats (column k of A, row k of B);
//   in_ready (LOAD), busy (LOAD+DRAIN), done (level), c_out (C[i][j] at i*N+j).
// Build option: define SYSTOLIC_SAT_EN for saturating accumulators + sat_flag.
module systolic_matmul_array #(
    parameter int N      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    input  logic                       acc_mode,
    input  logic                       a_valid,
    input  logic [N*DATA_W-1:0]        a_data,
    input  logic [N*DATA_W-1:0]        b_data,
    output logic                       in_ready,
    output logic                       busy,
    output logic                       done,
    output logic [N*N*ACC_W-1:0]       c_out
`ifdef SYSTOLIC_SAT_EN
    ,
    output logic                       sat_flag
`endif
);
    localparam int KW  = $clog2(K_MAX + 1);
    localparam int DCW = $clog2(2 * N);
    localparam int PW  = 2 * DATA_W;

    localparam logic [KW-1:0]  K_CAP  = KW'(K_MAX);
    localparam logic [DCW-1:0] D_LAST = DCW'(2 * N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    logic [KW-1:0]  k_reg;
    logic [KW-1:0]  beat_cnt;
    logic [DCW-1:0] drain_cnt;
    logic [KW-1:0]  k_eff;
    logic           take;
    logic           job_go;
    logic           acc_clr;

    assign k_eff   = (k_len > K_CAP) ? K_CAP : k_len;
    assign take    = a_valid && in_ready;
    assign job_go  = (state == S_IDLE) && start;
    assign acc_clr = job_go && !acc_mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            k_reg     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        k_reg    <= k_eff;
                        beat_cnt <= '0;
                        // a zero-length job completes without touching LOAD
                        done     <= (k_eff == '0);
                        if (k_eff == '0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_LOAD;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (take) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt == k_reg - KW'(1)) begin
                            state     <= S_DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    // last beat reaches PE(N-1,N-1) 2N-1 edges after accept
                    if (drain_cnt == D_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // non-accepted cycles inject zeros so bubbles add nothing
    logic [N*DATA_W-1:0] a_beat;
    logic [N*DATA_W-1:0] b_beat;

    assign a_beat = take ? a_data : '0;
    assign b_beat = take ? b_data : '0;

    logic signed [DATA_W-1:0] a_sk  [N][N-1];
    logic signed [DATA_W-1:0] b_sk  [N][N-1];
    logic signed [DATA_W-1:0] a_tap [N];
    logic signed [DATA_W-1:0] b_tap [N];
    logic signed [DATA_W-1:0] a_op  [N][N];
    logic signed [DATA_W-1:0] b_op  [N][N];
    logic signed [ACC_W-1:0]  acc     [N][N];
    logic signed [ACC_W-1:0]  acc_nxt [N][N];

    // row/column r enters the array after r skew registers
    for (genvar r = 0; r < N; r++) begin : g_tap
        if (r == 0) begin : g_direct
            assign a_tap[r] = a_beat[r*DATA_W +: DATA_W];
            assign b_tap[r] = b_beat[r*DATA_W +: DATA_W];
        end else begin : g_skew
            assign a_tap[r] = a_sk[r][r-1];
            assign b_tap[r] = b_sk[r][r-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d < N - 1; d++) begin
                    a_sk[i][d] <= '0;
                    b_sk[i][d] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    a_op[i][j] <= '0;
                    b_op[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_sk[i][0] <= a_beat[i*DATA_W +: DATA_W];
                b_sk[i][0] <= b_beat[i*DATA_W +: DATA_W];
                for (int d = 1; d < N - 1; d++) begin
                    a_sk[i][d] <= a_sk[i][d-1];
                    b_sk[i][d] <= b_sk[i][d-1];
                end
            end
            for (int i = 0; i < N; i++) begin
                a_op[i][0] <= a_tap[i];
                b_op[0][i] <= b_tap[i];
                for (int j = 1; j < N; j++) begin
                    a_op[i][j] <= a_op[i][j-1];
                    b_op[j][i] <= b_op[j-1][i];
                end
            end
        end
    end

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic sat_stk [N][N];
    logic sat_ev  [N][N];
    logic any_ev;
`endif

    always_comb begin : mac_blk
        logic signed [PW-1:0]    prod;
        logic signed [ACC_W-1:0] ext;
`ifdef SYSTOLIC_SAT_EN
        logic signed [ACC_W:0]   sum;
        any_ev = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod = PW'(a_op[i][j]) * PW'(b_op[i][j]);
                ext  = ACC_W'(prod);
`ifdef SYSTOLIC_SAT_EN
                sum = (ACC_W+1)'(acc[i][j]) + (ACC_W+1)'(ext);
                sat_ev[i][j] = 1'b0;
                if (sat_stk[i][j]) begin
                    acc_nxt[i][j] = acc[i][j];
                end else if (sum[ACC_W] != sum[ACC_W-1]) begin
                    acc_nxt[i][j] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    sat_ev[i][j]  = 1'b1;
                end else begin
                    acc_nxt[i][j] = sum[ACC_W-1:0];
                end
                any_ev = any_ev | sat_ev[i][j];
`else
                acc_nxt[i][j] = acc[i][j] + ext;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
`ifdef SYSTOLIC_SAT_EN
                    sat_stk[i][j] <= 1'b0;
`endif
                end
            end
`ifdef SYSTOLIC_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc_clr ? '0 : acc_nxt[i][j];
`ifdef SYSTOLIC_SAT_EN
                    // saturation sticks only for the job in flight
                    sat_stk[i][j] <= job_go ? 1'b0
                                            : (sat_stk[i][j] | sat_ev[i][j]);
`endif
                end
            end
`ifdef SYSTOLIC_SAT_EN
            sat_flag <= acc_clr ? 1'b0 : (sat_flag | any_ev);
`endif
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign c_out[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_matmul_array.sv
// tb_systolic_matmul_array: randomized and directed jobs against a
// matrix-level reference model of systolic_matmul_array.
module tb_systolic_matmul_array;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int KM = 8;
    localparam int KW = $clog2(KM + 1);

    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -longint'(2147483647) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            acc_mode;
    logic            a_valid;
    logic [N*DW-1:0] a_data;
    logic [N*DW-1:0] b_data;
    logic            in_ready;
    logic            busy;
    logic            done;
    logic [N*N*AW-1:0] c_out;
`ifdef SYSTOLIC_SAT_EN
    logic            sat_flag;
`endif

    int n_chk = 0;
    int n_err = 0;

    int ma [N][KM];
    int mb [KM][N];
    int mc [N][N];
    bit mstk [N][N];
    bit msat;

    systolic_matmul_array #(
        .N(N), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .k_len(k_len),
        .acc_mode(acc_mode),
        .a_valid(a_valid),
        .a_data(a_data),
        .b_data(b_data),
        .in_ready(in_ready),
        .busy(busy),
        .done(done),
        .c_out(c_out)
`ifdef SYSTOLIC_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // C = A x B over k terms, row by row of the result
    task automatic model_job(input int k, input bit accm);
        longint p;
        longint s;
        if (!accm) begin
            msat = 1'b0;
            foreach (mc[i, j]) mc[i][j] = 0;
        end
        foreach (mstk[i, j]) mstk[i][j] = 1'b0;
        for (int kk = 0; kk < k; kk++) begin
            foreach (mc[i, j]) begin
                p = longint'(ma[i][kk]) * longint'(mb[kk][j]);
`ifdef SYSTOLIC_SAT_EN
                if (!mstk[i][j]) begin
                    s = longint'(mc[i][j]) + p;
                    if (s > SMAX || s < SMIN) begin
                        s = (s > SMAX) ? SMAX : SMIN;
                        mstk[i][j] = 1'b1;
                        msat = 1'b1;
                    end
                    mc[i][j] = int'(s);
                end
`else
                s = p;
                mc[i][j] = mc[i][j] + int'(s);
`endif
            end
        end
    endtask

    task automatic check_result(input string tag);
        logic [AW-1:0] e;
        foreach (mc[i, j]) begin
            e = mc[i][j];
            check($sformatf("%s_c%0d%0d", tag, i, j),
                  c_out[(i*N+j)*AW +: AW], e);
        end
`ifdef SYSTOLIC_SAT_EN
        check({tag, "_sat"}, sat_flag, msat);
`endif
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < N; i++) begin
            a_data[i*DW +: DW] = DW'(ma[i][kk]);
            b_data[i*DW +: DW] = DW'(mb[kk][i]);
        end
    endtask

    task automatic drive_junk();
        for (int i = 0; i < N; i++) begin
            a_data[i*DW +: DW] = DW'($urandom);
            b_data[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // mode 0: continuous, 1: alternate bubbles, 2: random bubbles
    task automatic run_job(input int k, input bit accm, input int mode,
                           input bit poke, input string tag);
        int keff;
        int beats;
        int cyc;
        int lat;
        bit took;
        keff = (k > KM) ? KM : k;
        beats = 0;
        cyc = 0;
        start = 1'b1;
        k_len = KW'(k);
        acc_mode = accm;
        tick();
        start = 1'b0;
        model_job(keff, accm);
        if (keff == 0) begin
            check({tag, "_done"}, done, 1'b1);
            check({tag, "_busy"}, busy, 1'b0);
            check_result(tag);
            tick();
            check({tag, "_busy2"}, busy, 1'b0);
            check({tag, "_held"}, done, 1'b1);
            return;
        end
        check({tag, "_dclr"}, done, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
        while (beats < keff && cyc < 200) begin
            case (mode)
                0: a_valid = 1'b1;
                1: a_valid = (cyc % 2) == 1;
                default: a_valid = $urandom_range(99) >= 40;
            endcase
            if (a_valid) drive_beat(beats);
            else drive_junk();
            took = a_valid && in_ready;
            tick();
            cyc++;
            if (took) beats++;
        end
        a_valid = 1'b0;
        drive_junk();
        check({tag, "_beats"}, beats, keff);
        check({tag, "_rdy"}, in_ready, 1'b0);
        lat = 0;
        while (!done && lat < 40) begin
            if (poke && lat == 1) begin
                start = 1'b1;
                k_len = '0;
                acc_mode = 1'b0;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, lat, 2 * N);
        check({tag, "_bfall"}, busy, 1'b0);
        check_result(tag);
        tick();
        check({tag, "_held"}, done, 1'b1);
    endtask

    task automatic fill_const(input int av, input int bv);
        foreach (ma[i, k]) ma[i][k] = av;
        foreach (mb[k, j]) mb[k][j] = bv;
    endtask

    task automatic fill_rand();
        logic signed [DW-1:0] r;
        foreach (ma[i, k]) begin
            r = DW'($urandom);
            ma[i][k] = r;
        end
        foreach (mb[k, j]) begin
            r = DW'($urandom);
            mb[k][j] = r;
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        k_len = '0;
        acc_mode = 1'b0;
        a_valid = 1'b0;
        a_data = '0;
        b_data = '0;
        msat = 1'b0;
        foreach (mc[i, j]) mc[i][j] = 0;
        repeat (3) tick();
        check("rst_c", |c_out, 1'b0);
        check("rst_rdy", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;
        tick();

        fill_const(0, 0);
        for (int kk = 0; kk < N; kk++) begin
            ma[kk][kk] = 1;
            for (int j = 0; j < N; j++) mb[kk][j] = kk * N + j + 1;
        end
        run_job(3, 1'b0, 0, 1'b0, "ident");
        check("ident_c11", c_out[4*AW +: AW], 5);
        run_job(3, 1'b0, 1, 1'b0, "ident_alt");
        check("alt_c22", c_out[8*AW +: AW], 9);

        fill_const(2, 3);
        run_job(2, 1'b0, 0, 1'b0, "j1");
        check("j1_c00", c_out[0 +: AW], 12);
        run_job(2, 1'b1, 2, 1'b1, "j2");
        check("j2_c12", c_out[5*AW +: AW], 24);
        run_job(2, 1'b0, 0, 1'b0, "j3");
        check("j3_c21", c_out[7*AW +: AW], 12);

        run_job(0, 1'b0, 0, 1'b0, "kzero");

        fill_rand();
        run_job(3, 1'b0, 0, 1'b0, "pre_rst");
        start = 1'b1;
        k_len = KW'(3);
        acc_mode = 1'b1;
        tick();
        start = 1'b0;
        a_valid = 1'b1;
        drive_beat(0);
        tick();
        a_valid = 1'b0;
        check("mid_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_c", |c_out, 1'b0);
        check("mid_rdy", in_ready, 1'b0);
        check("mid_bsy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        start = 1'b1;
        acc_mode = 1'b0;
        tick();
        start = 1'b0;
        rst = 1'b1;
        tick();
        check("ign_busy", busy, 1'b0);
        check("ign_rdy", in_ready, 1'b0);
        msat = 1'b0;
        foreach (mc[i, j]) mc[i][j] = 0;
        run_job(3, 1'b1, 0, 1'b0, "post_rst");

        fill_const(32767, 32767);
        run_job(8, 1'b0, 0, 1'b0, "big");

        for (int t = 0; t < 24; t++) begin
            fill_rand();
            run_job(int'($urandom_range(10)), 1'($urandom_range(1)), 2,
                    1'($urandom_range(1)), $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
